// File: rtl/iob_pcie_tx_arb_pkg.sv
// iob_pcie_tx_arb_pkg: shared state encoding and beat-count helper for the PCIe TX arbiter
package iob_pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } txarb_state_t;

    // Beat counter is one bit wider than the length so ceil() cannot overflow at len = 2^32-1
    localparam int BEAT_CNT_W = 33;

    // Number of channel beats needed to move len 32-bit words, bw words per beat
    function automatic logic [BEAT_CNT_W-1:0] beats_of(input logic [31:0] len, input int bw);
        logic [BEAT_CNT_W-1:0] w_sum;
        w_sum = {1'b0, len} + BEAT_CNT_W'(bw - 1);
        return w_sum / BEAT_CNT_W'(bw);
    endfunction

endpackage

// File: rtl/iob_pcie_rr_arb.sv
// iob_pcie_rr_arb: round-robin grant from a request vector, pointer advances past each grant
module iob_pcie_rr_arb #(
    parameter int N_REQ = 2,
    parameter int GW    = 1
) (
    input  logic             PCIE_CLK,
    input  logic             PCIE_RST,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_upd,
    output logic [N_REQ-1:0] o_grant_oh,
    output logic [GW-1:0]    o_grant_id,
    output logic             o_any
);

    logic [GW-1:0] r_ptr;

    // Search from the pointer upward with wrap; scanning downward lets the nearest request win
    always_comb begin
        o_grant_oh = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[(int'(r_ptr) + k) % N_REQ]) begin
                o_any      = 1'b1;
                o_grant_id = GW'((int'(r_ptr) + k) % N_REQ);
            end
        end
        o_grant_oh[o_grant_id] = o_any;
    end

    // Pointer moves to the requester after the one just granted
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST)
            r_ptr <= '0;
        else if (i_upd && o_any)
            r_ptr <= (int'(o_grant_id) == N_REQ - 1) ? '0 : o_grant_id + 1'b1;
    end

endmodule

// File: rtl/iob_pcie_tx_arb.sv
// iob_pcie_tx_arb: round-robin sharing of the PCIe CHNL_TX channel among N_REQ data sources
// Optional stall timeout enabled by defining IOB_PCIE_TXARB_TIMEOUT_EN.
module iob_pcie_tx_arb
    import iob_pcie_tx_arb_pkg::*;
#(
    parameter int N_REQ            = 2,
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int TIMEOUT_CYC      = 4096,
    localparam int GW              = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          PCIE_CLK,
    input  logic                          PCIE_RST,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*32-1:0]           req_len,
    output logic [N_REQ-1:0]              req_ack,
    input  logic [N_REQ*C_PCI_DATA_WIDTH-1:0] src_data,
    input  logic [N_REQ-1:0]              src_valid,
    output logic [N_REQ-1:0]              src_ren,
    output logic                          PCIE_CHNL_TX,
    input  logic                          PCIE_CHNL_TX_ACK,
    output logic                          PCIE_CHNL_TX_LAST,
    output logic [31:0]                   PCIE_CHNL_TX_LEN,
    output logic [30:0]                   PCIE_CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0]   PCIE_CHNL_TX_DATA,
    output logic                          PCIE_CHNL_TX_DATA_VALID,
    input  logic                          PCIE_CHNL_TX_DATA_REN,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic                          done,
    output logic                          err
);

    localparam int BEAT_WORDS = C_PCI_DATA_WIDTH / 32;

    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_nreq
        $error("iob_pcie_tx_arb: N_REQ must be 1..8");
    end
    if (BEAT_WORDS < 1) begin : g_bad_width
        $error("iob_pcie_tx_arb: C_PCI_DATA_WIDTH must be at least 32");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("iob_pcie_tx_arb: TIMEOUT_CYC must be at least 1");
    end

    txarb_state_t            r_state;
    txarb_state_t            w_next;
    logic [31:0]             r_len;
    logic [GW-1:0]           r_gid;
    logic [BEAT_CNT_W-1:0]   r_beats;
    logic [N_REQ-1:0]        w_grant_oh;
    logic [GW-1:0]           w_gid;
    logic                    w_any;
    logic                    w_ld;
    logic [31:0]             w_len_sel;
    logic                    w_chnl;
    logic                    w_xfer;
    logic                    w_beat;
    logic                    w_timeout;

    iob_pcie_rr_arb #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_rr (
        .PCIE_CLK   (PCIE_CLK),
        .PCIE_RST   (PCIE_RST),
        .i_req      (req_valid),
        .i_upd      (r_state == ST_IDLE),
        .o_grant_oh (w_grant_oh),
        .o_grant_id (w_gid),
        .o_any      (w_any)
    );

    assign w_len_sel = req_len[w_gid*32 +: 32];
    assign w_chnl    = (r_state == ST_OPEN) || (r_state == ST_XFER);
    assign w_xfer    = (r_state == ST_XFER);
    assign w_beat    = PCIE_CHNL_TX_DATA_VALID && PCIE_CHNL_TX_DATA_REN;

    assign busy                    = (r_state != ST_IDLE);
    assign done                    = (r_state == ST_DONE);
    assign grant_id                = r_gid;
    assign PCIE_CHNL_TX            = w_chnl;
    assign PCIE_CHNL_TX_LAST       = w_chnl;
    assign PCIE_CHNL_TX_LEN        = r_len;
    assign PCIE_CHNL_TX_OFF        = '0;
    assign PCIE_CHNL_TX_DATA       = w_xfer ? src_data[r_gid*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH] : '0;
    assign PCIE_CHNL_TX_DATA_VALID = w_xfer && src_valid[r_gid];
    assign err                     = w_timeout;

    // Ack the grantee while idle and pop the grantee's source only on an actual beat
    always_comb begin
        req_ack = (r_state == ST_IDLE) ? w_grant_oh : '0;
        src_ren = '0;
        if (w_beat)
            src_ren[r_gid] = 1'b1;
    end

    // Next-state logic; a stall timeout overrides any transition back to IDLE
    always_comb begin
        w_next = r_state;
        w_ld   = 1'b0;
        case (r_state)
            ST_IDLE: if (w_any) begin
                w_ld   = 1'b1;
                w_next = (w_len_sel == 32'd0) ? ST_DONE : ST_OPEN;
            end
            ST_OPEN: if (PCIE_CHNL_TX_ACK) w_next = ST_XFER;
            ST_XFER: if (w_beat && r_beats == BEAT_CNT_W'(1)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_timeout)
            w_next = ST_IDLE;
    end

    // State register
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Latch the grantee's length and id at grant; count down remaining beats
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            r_len   <= '0;
            r_gid   <= '0;
            r_beats <= '0;
        end else if (w_ld) begin
            r_len   <= w_len_sel;
            r_gid   <= w_gid;
            r_beats <= beats_of(w_len_sel, BEAT_WORDS);
        end else if (w_beat) begin
            r_beats <= r_beats - 1'b1;
        end
    end

`ifdef IOB_PCIE_TXARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);

    logic [SW-1:0] r_stall;

    assign w_timeout = w_chnl && !w_beat && (r_stall == SW'(TIMEOUT_CYC - 1));

    // Stall counter runs only while the channel is open and restarts on progress
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST)
            r_stall <= '0;
        else
            r_stall <= (!w_chnl || w_beat || w_next != r_state) ? '0 : r_stall + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_iob_pcie_tx_arb.sv
// tb_iob_pcie_tx_arb: directed self-checking bench for the PCIe TX round-robin arbiter
module tb_iob_pcie_tx_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [63:0]  req_len;
    logic [1:0]   req_ack;
    logic [127:0] src_data;
    logic [1:0]   src_valid;
    logic [1:0]   src_ren;
    logic         tx;
    logic         tx_ack;
    logic         tx_last;
    logic [31:0]  tx_len;
    logic [30:0]  tx_off;
    logic [63:0]  tx_data;
    logic         tx_dv;
    logic         tx_ren;
    logic         busy;
    logic [0:0]   gid;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iob_pcie_tx_arb #(
        .N_REQ            (2),
        .C_PCI_DATA_WIDTH (64),
        .TIMEOUT_CYC      (16)
    ) dut (
        .PCIE_CLK                (clk),
        .PCIE_RST                (rst),
        .req_valid               (req_valid),
        .req_len                 (req_len),
        .req_ack                 (req_ack),
        .src_data                (src_data),
        .src_valid               (src_valid),
        .src_ren                 (src_ren),
        .PCIE_CHNL_TX            (tx),
        .PCIE_CHNL_TX_ACK        (tx_ack),
        .PCIE_CHNL_TX_LAST       (tx_last),
        .PCIE_CHNL_TX_LEN        (tx_len),
        .PCIE_CHNL_TX_OFF        (tx_off),
        .PCIE_CHNL_TX_DATA       (tx_data),
        .PCIE_CHNL_TX_DATA_VALID (tx_dv),
        .PCIE_CHNL_TX_DATA_REN   (tx_ren),
        .busy                    (busy),
        .grant_id                (gid),
        .done                    (done),
        .err                     (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_len   = '0;
        src_data  = '0;
        src_valid = '0;
        tx_ack    = 1'b0;
        tx_ren    = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++;
        if ({tx, tx_last, tx_dv, busy, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000000", {tx, tx_last, tx_dv, busy, done, err});
        end
        total++;
        if ({req_ack, src_ren, gid} !== 5'b0 || tx_len !== 32'd0 || tx_off !== 31'd0) begin
            bad++;
            $display("FAIL reset_vals ack=%b ren=%b gid=%0d len=%0d", req_ack, src_ren, gid, tx_len);
        end
    endtask

    task automatic test_single;
        req_len[31:0] = 32'd8;
        req_valid     = 2'b01;
        #1;
        total++;
        if (req_ack !== 2'b01) begin
            bad++;
            $display("FAIL single_ack got=%b exp=01", req_ack);
        end
        tick();
        req_valid = 2'b00;
        #1;
        total++;
        if ({tx, tx_last, tx_dv} !== 3'b110 || tx_len !== 32'd8 || tx_off !== 31'd0 || gid !== 1'b0) begin
            bad++;
            $display("FAIL single_open tx/last/dv=%b len=%0d gid=%0d exp 110 8 0", {tx, tx_last, tx_dv}, tx_len, gid);
        end
        tick();
        total++;
        if (tx !== 1'b1 || req_ack !== 2'b00 || tx_dv !== 1'b0) begin
            bad++;
            $display("FAIL single_wait_ack tx=%b ack=%b dv=%b exp 1 00 0", tx, req_ack, tx_dv);
        end
        tx_ack = 1'b1;
        tick();
        tx_ack    = 1'b0;
        src_valid = 2'b01;
        tx_ren    = 1'b1;
        for (int b = 0; b < 4; b++) begin
            src_data[63:0] = 64'hA000 + 64'(b);
            #1;
            total++;
            if (tx_data !== 64'hA000 + 64'(b) || src_ren !== 2'b01 || tx !== 1'b1) begin
                bad++;
                $display("FAIL single_beat%0d data=%h ren=%b tx=%b exp %h 01 1", b, tx_data, src_ren, tx, 64'hA000 + 64'(b));
            end
            tick();
        end
        #1;
        total++;
        if ({done, tx, busy} !== 3'b101) begin
            bad++;
            $display("FAIL single_done done/tx/busy=%b exp=101", {done, tx, busy});
        end
        tick();
        src_valid = 2'b00;
        tx_ren    = 1'b0;
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL single_idle done/busy=%b exp=00", {done, busy});
        end
    endtask

    task automatic test_alternate;
        logic [1:0]  exp_oh;
        logic [0:0]  exp_id;
        logic [63:0] exp_data;
        do_reset();
        req_len   = {32'd4, 32'd4};
        src_data  = {64'hBBBB_0001, 64'hAAAA_0000};
        src_valid = 2'b11;
        tx_ren    = 1'b1;
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_oh   = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_id   = (t % 2 == 0) ? 1'b0 : 1'b1;
            exp_data = (t % 2 == 0) ? 64'hAAAA_0000 : 64'hBBBB_0001;
            #1;
            total++;
            if (req_ack !== exp_oh || busy !== 1'b0) begin
                bad++;
                $display("FAIL alt%0d_grant ack=%b busy=%b exp %b 0", t, req_ack, busy, exp_oh);
            end
            tick();
            total++;
            if (gid !== exp_id || tx !== 1'b1 || req_ack !== 2'b00) begin
                bad++;
                $display("FAIL alt%0d_open gid=%0d tx=%b ack=%b exp %0d 1 00", t, gid, tx, req_ack, exp_id);
            end
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
            for (int b = 0; b < 2; b++) begin
                #1;
                total++;
                if (src_ren !== exp_oh || tx_data !== exp_data) begin
                    bad++;
                    $display("FAIL alt%0d_beat%0d ren=%b data=%h exp %b %h", t, b, src_ren, tx_data, exp_oh, exp_data);
                end
                tick();
            end
            total++;
            if (done !== 1'b1 || tx !== 1'b0) begin
                bad++;
                $display("FAIL alt%0d_done done=%b tx=%b exp 1 0", t, done, tx);
            end
            tick();
        end
        req_valid = 2'b00;
        src_valid = 2'b00;
        tx_ren    = 1'b0;
        tick();
    endtask

    task automatic test_odd_zero;
        int n;
        int c;
        req_len[31:0] = 32'd5;
        req_valid     = 2'b01;
        tick();
        req_valid = 2'b00;
        #1;
        total++;
        if (tx_len !== 32'd5 || tx !== 1'b1) begin
            bad++;
            $display("FAIL odd_len len=%0d tx=%b exp 5 1", tx_len, tx);
        end
        tx_ack = 1'b1;
        tick();
        tx_ack    = 1'b0;
        src_valid = 2'b01;
        tx_ren    = 1'b1;
        n = 0;
        for (c = 0; c < 10; c++) begin
            #1;
            if (done) break;
            if (tx_dv && tx_ren) n++;
            tick();
        end
        total++;
        if (n !== 3 || c >= 10) begin
            bad++;
            $display("FAIL odd_beats got=%0d exp=3 (cycles %0d)", n, c);
        end
        tick();
        src_valid = 2'b00;
        tx_ren    = 1'b0;
        req_len[63:32] = 32'd0;
        req_valid      = 2'b10;
        #1;
        total++;
        if (req_ack !== 2'b10 || tx !== 1'b0) begin
            bad++;
            $display("FAIL zero_ack ack=%b tx=%b exp 10 0", req_ack, tx);
        end
        tick();
        req_valid = 2'b00;
        #1;
        total++;
        if (done !== 1'b1 || tx !== 1'b0) begin
            bad++;
            $display("FAIL zero_done done=%b tx=%b exp 1 0", done, tx);
        end
        tick();
        total++;
        if ({busy, tx, done} !== 3'b000) begin
            bad++;
            $display("FAIL zero_idle busy/tx/done=%b exp=000", {busy, tx, done});
        end
    endtask

    task automatic test_gaps;
        int k;
        int c;
        logic beat;
        req_len[31:0] = 32'd16;
        req_valid     = 2'b01;
        tick();
        req_valid = 2'b00;
        tx_ack    = 1'b1;
        tick();
        tx_ack = 1'b0;
        k = 0;
        for (c = 0; c < 100; c++) begin
            src_data[63:0] = 64'hD00 + 64'(k);
            src_valid[0]   = (c % 3 != 1);
            tx_ren         = (c % 4 != 2);
            #1;
            if (done) break;
            beat = src_valid[0] && tx_ren;
            if (src_valid[0]) begin
                total++;
                if (tx_data !== 64'hD00 + 64'(k) || tx_dv !== 1'b1) begin
                    bad++;
                    $display("FAIL gaps_data%0d got=%h dv=%b exp=%h", k, tx_data, tx_dv, 64'hD00 + 64'(k));
                end
            end
            if (src_valid[0] || !tx_ren) begin
                total++;
                if (src_ren !== {1'b0, beat}) begin
                    bad++;
                    $display("FAIL gaps_ren cyc%0d got=%b exp=%b", c, src_ren, {1'b0, beat});
                end
            end
            if (beat) k++;
            tick();
        end
        total++;
        if (k !== 8 || c >= 100) begin
            bad++;
            $display("FAIL gaps_beats got=%0d exp=8 (cycles %0d)", k, c);
        end
        tick();
        src_valid = 2'b00;
        tx_ren    = 1'b0;
    endtask

    task automatic test_reset_mid;
        req_len   = {32'd8, 32'd8};
        req_valid = 2'b10;
        #1;
        total++;
        if (req_ack !== 2'b10) begin
            bad++;
            $display("FAIL rstmid_ack got=%b exp=10", req_ack);
        end
        tick();
        req_valid = 2'b00;
        tx_ack    = 1'b1;
        tick();
        tx_ack    = 1'b0;
        src_valid = 2'b10;
        tx_ren    = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({tx, tx_last, tx_dv, busy, done, err} !== 6'b0 || src_ren !== 2'b00 || gid !== 1'b0 || tx_len !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_outputs flags=%b ren=%b gid=%0d len=%0d exp all 0",
                     {tx, tx_last, tx_dv, busy, done, err}, src_ren, gid, tx_len);
        end
        src_valid = 2'b00;
        tx_ren    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if ({done, busy, tx} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_nodone done/busy/tx=%b exp=000", {done, busy, tx});
        end
        req_len   = {32'd4, 32'd4};
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ack !== 2'b01) begin
            bad++;
            $display("FAIL rstmid_ptr ack=%b exp=01", req_ack);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_timeout;
        req_len[31:0] = 32'd4;
        req_valid     = 2'b01;
        tick();
        req_valid = 2'b00;
`ifdef IOB_PCIE_TXARB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            #1;
            total++;
            if (err !== 1'b0 || tx !== 1'b1) begin
                bad++;
                $display("FAIL timeout_early cyc%0d err=%b tx=%b exp 0 1", c, err, tx);
            end
            tick();
        end
        #1;
        total++;
        if (err !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err err=%b done=%b exp 1 0", err, done);
        end
        tick();
        total++;
        if ({tx, err, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL timeout_after tx/err/busy/done=%b exp=0000", {tx, err, busy, done});
        end
`else
        for (int c = 1; c <= 20; c++) begin
            #1;
            total++;
            if (err !== 1'b0 || tx !== 1'b1) begin
                bad++;
                $display("FAIL notimeout cyc%0d err=%b tx=%b exp 0 1", c, err, tx);
            end
            tick();
        end
        do_reset();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_odd_zero();
        test_gaps();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
